// File: rtl/rob_if.sv
// rob_if: bundles the reorder buffer's rename, execute, commit and status
// signals so they travel as one port.
//   slave  : the reorder buffer (consumes alloc/wb/commit_ready, produces the rest)
//   master : whoever drives rename/execute/commit (consumes ROB outputs)
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The offering side holds its payload stable while valid is high and
// ready is low. Writeback ports have no ready; a strobe is always consumed.
interface rob_if #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int PC_W     = 32,
  parameter int AREG_W   = 5,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int WB_PORTS = 2
);
  // allocation from rename
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [PC_W-1:0]            alloc_pc;
  logic [AREG_W-1:0]          alloc_lrd;
  logic [PREG_W-1:0]          alloc_prd;
  logic                       alloc_is_store;
  logic                       alloc_is_load;
  logic                       alloc_is_branch;
  logic                       alloc_pred_taken;
  logic [PC_W-1:0]            alloc_pred_target;
  logic [IDX_W-1:0]           alloc_idx;
  // completions from execute
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*IDX_W-1:0]  wb_idx;
  logic [WB_PORTS*DATA_W-1:0] wb_result;
  logic [WB_PORTS-1:0]        wb_taken;
  logic [WB_PORTS*PC_W-1:0]   wb_target;
  // retirement to commit
  logic                       commit_valid;
  logic                       commit_ready;
  logic [PC_W-1:0]            commit_pc;
  logic [AREG_W-1:0]          commit_lrd;
  logic [PREG_W-1:0]          commit_prd;
  logic [DATA_W-1:0]          commit_result;
  logic                       commit_is_store;
  logic                       commit_is_load;
  // recovery and status
  logic                       flush;
  logic [PC_W-1:0]            redirect_pc;
  logic [IDX_W:0]             count;
  logic                       full;
  logic                       empty;

  modport slave (
    input  alloc_valid, alloc_pc, alloc_lrd, alloc_prd, alloc_is_store,
           alloc_is_load, alloc_is_branch, alloc_pred_taken, alloc_pred_target,
           wb_valid, wb_idx, wb_result, wb_taken, wb_target, commit_ready,
    output alloc_ready, alloc_idx, commit_valid, commit_pc, commit_lrd,
           commit_prd, commit_result, commit_is_store, commit_is_load,
           flush, redirect_pc, count, full, empty
  );

  modport master (
    output alloc_valid, alloc_pc, alloc_lrd, alloc_prd, alloc_is_store,
           alloc_is_load, alloc_is_branch, alloc_pred_taken, alloc_pred_target,
           wb_valid, wb_idx, wb_result, wb_taken, wb_target, commit_ready,
    input  alloc_ready, alloc_idx, commit_valid, commit_pc, commit_lrd,
           commit_prd, commit_result, commit_is_store, commit_is_load,
           flush, redirect_pc, count, full, empty
  );
endinterface

// File: rtl/rob_buffer.sv
// rob_buffer: reorder buffer with internal head/tail pointers. One in-order
// allocation per cycle, WB_PORTS out-of-order completions per cycle, one
// in-order retirement per cycle. A mispredicted branch is resolved when it
// retires: flush/redirect_pc fire that cycle and all younger entries drop.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rob_if.slave (alloc_*, wb_*, commit_*, flush, redirect_pc,
//           count, full, empty)
// Optional build macro ROB_WB_BYPASS_EN: a writeback hitting the head index
// makes it retireable in the same cycle, with result/taken/target taken from
// that port. Without it, writeback is visible one cycle later.
module rob_buffer #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int PC_W     = 32,
  parameter int AREG_W   = 5,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int WB_PORTS = 2
) (
  input logic  clk,
  input logic  rst_n,
  rob_if.slave bus
);
  localparam int PTR_W = IDX_W + 1;

  // pointers carry a wrap bit above the index bits
  logic [PTR_W-1:0] head, tail;
  logic [DEPTH-1:0] valid, done;

  logic [PC_W-1:0]   pc_q          [DEPTH];
  logic [AREG_W-1:0] lrd_q         [DEPTH];
  logic [PREG_W-1:0] prd_q         [DEPTH];
  logic              is_store_q    [DEPTH];
  logic              is_load_q     [DEPTH];
  logic              is_branch_q   [DEPTH];
  logic              pred_taken_q  [DEPTH];
  logic [PC_W-1:0]   pred_target_q [DEPTH];
  logic [DATA_W-1:0] result_q      [DEPTH];
  logic              taken_q       [DEPTH];
  logic [PC_W-1:0]   target_q      [DEPTH];

  logic [IDX_W-1:0]  h, t;
  logic              hd_done, hd_taken;
  logic [PC_W-1:0]   hd_target;
  logic [DATA_W-1:0] hd_result;
  logic              retire, mispredict, alloc_fire;

  assign h = head[IDX_W-1:0];
  assign t = tail[IDX_W-1:0];

  // head entry view, optionally overridden by a same-cycle writeback
  always_comb begin
    hd_done   = done[h];
    hd_taken  = taken_q[h];
    hd_target = target_q[h];
    hd_result = result_q[h];
`ifdef ROB_WB_BYPASS_EN
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p] && (bus.wb_idx[p*IDX_W +: IDX_W] == h)) begin
        hd_done   = 1'b1;
        hd_taken  = bus.wb_taken[p];
        hd_target = bus.wb_target[p*PC_W +: PC_W];
        hd_result = bus.wb_result[p*DATA_W +: DATA_W];
      end
    end
`else
`endif
  end

  assign bus.full  = (head[IDX_W] != tail[IDX_W]) && (h == t);
  assign bus.empty = (head == tail);
  assign bus.count = tail - head;

  assign bus.commit_valid    = valid[h] && hd_done;
  assign bus.commit_pc       = pc_q[h];
  assign bus.commit_lrd      = lrd_q[h];
  assign bus.commit_prd      = prd_q[h];
  assign bus.commit_result   = hd_result;
  assign bus.commit_is_store = is_store_q[h];
  assign bus.commit_is_load  = is_load_q[h];

  assign retire     = bus.commit_valid && bus.commit_ready;
  assign mispredict = is_branch_q[h] &&
                      ((pred_taken_q[h] != hd_taken) ||
                       (hd_taken && (pred_target_q[h] != hd_target)));
  assign bus.flush  = retire && mispredict;
  assign bus.redirect_pc = !bus.flush ? '0 :
                           hd_taken   ? hd_target : (pc_q[h] + PC_W'(4));

  // flush blocks allocation so the squash never races a new entry
  assign bus.alloc_ready = !bus.full && !bus.flush;
  assign bus.alloc_idx   = t;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

  // control state: pointers and valid/done bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && valid[bus.wb_idx[p*IDX_W +: IDX_W]])
          done[bus.wb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
      end
      if (bus.flush) begin
        // the branch retires; everything younger is discarded
        valid <= '0;
        head  <= head + PTR_W'(1);
        tail  <= head + PTR_W'(1);
      end else begin
        if (retire) begin
          valid[h] <= 1'b0;
          head     <= head + PTR_W'(1);
        end
        if (alloc_fire) begin
          valid[t] <= 1'b1;
          done[t]  <= 1'b0;
          tail     <= tail + PTR_W'(1);
        end
      end
    end
  end

  // payload storage, no reset needed; later ports overwrite earlier ones
  always_ff @(posedge clk) begin
    for (int p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p] && valid[bus.wb_idx[p*IDX_W +: IDX_W]]) begin
        result_q[bus.wb_idx[p*IDX_W +: IDX_W]] <= bus.wb_result[p*DATA_W +: DATA_W];
        taken_q[bus.wb_idx[p*IDX_W +: IDX_W]]  <= bus.wb_taken[p];
        target_q[bus.wb_idx[p*IDX_W +: IDX_W]] <= bus.wb_target[p*PC_W +: PC_W];
      end
    end
    if (alloc_fire) begin
      pc_q[t]          <= bus.alloc_pc;
      lrd_q[t]         <= bus.alloc_lrd;
      prd_q[t]         <= bus.alloc_prd;
      is_store_q[t]    <= bus.alloc_is_store;
      is_load_q[t]     <= bus.alloc_is_load;
      is_branch_q[t]   <= bus.alloc_is_branch;
      pred_taken_q[t]  <= bus.alloc_pred_taken;
      pred_target_q[t] <= bus.alloc_pred_target;
    end
  end
endmodule

// File: tb/tb_rob_buffer.sv
// tb_rob_buffer: directed checks of rob_buffer (default build) with
// hand-computed expectations: reset, fill to full, out-of-order writeback,
// mispredict flush/redirect, port priority, ignored writeback, wrap-around
// streaming and asynchronous reset.
module tb_rob_buffer;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  rob_if bus ();

  rob_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.alloc_valid       = 1'b0;
    bus.alloc_pc          = '0;
    bus.alloc_lrd         = '0;
    bus.alloc_prd         = '0;
    bus.alloc_is_store    = 1'b0;
    bus.alloc_is_load     = 1'b0;
    bus.alloc_is_branch   = 1'b0;
    bus.alloc_pred_taken  = 1'b0;
    bus.alloc_pred_target = '0;
    bus.wb_valid          = '0;
    bus.wb_idx            = '0;
    bus.wb_result         = '0;
    bus.wb_taken          = '0;
    bus.wb_target         = '0;
    bus.commit_ready      = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic br, input logic pt,
                           input logic [31:0] ptgt);
    bus.alloc_valid       = 1'b1;
    bus.alloc_pc          = pc;
    bus.alloc_lrd         = pc[6:2];
    bus.alloc_prd         = pc[7:2];
    bus.alloc_is_store    = pc[2];
    bus.alloc_is_load     = pc[3];
    bus.alloc_is_branch   = br;
    bus.alloc_pred_taken  = pt;
    bus.alloc_pred_target = ptgt;
  endtask

  task automatic set_wb(input int p, input logic [3:0] idx, input logic [31:0] res,
                        input logic tk, input logic [31:0] tgt);
    bus.wb_valid[p]          = 1'b1;
    bus.wb_idx[p*4 +: 4]     = idx;
    bus.wb_result[p*32 +: 32] = res;
    bus.wb_taken[p]          = tk;
    bus.wb_target[p*32 +: 32] = tgt;
  endtask

  initial begin
    logic [31:0] pc;
    clr();
    rst_n = 1'b0;
    #1;
    // reset state
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_redirect", bus.redirect_pc, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fill to full, no writeback
    for (int k = 0; k < 16; k++) begin
      set_alloc(32'h100 + 32'(4*k), 1'b0, 1'b0, 32'h0);
      #1;
      chk("fill_idx", bus.alloc_idx, 64'(k));
      chk("fill_ready", bus.alloc_ready, 1);
      tick();
      clr();
    end
    #1;
    chk("full_flag", bus.full, 1);
    chk("full_ready", bus.alloc_ready, 0);
    chk("full_count", bus.count, 16);
    chk("full_commit_valid", bus.commit_valid, 0);
    chk("full_empty", bus.empty, 0);

    // out-of-order writeback, in-order retirement
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_alloc(32'h100 + 32'(4*k), 1'b0, 1'b0, 32'h0);
      tick();
      clr();
    end
    set_wb(0, 4'd2, 32'hA, 1'b0, 32'h0);
    tick(); clr(); #1;
    chk("ooo_cv_after_idx2", bus.commit_valid, 0);
    set_wb(0, 4'd0, 32'hB, 1'b0, 32'h0);
    tick(); clr(); #1;
    chk("ooo_cv_after_idx0", bus.commit_valid, 1);
    set_wb(1, 4'd1, 32'hC, 1'b0, 32'h0);
    tick(); clr();
    bus.commit_ready = 1'b1;
    #1;
    chk("ooo_pc0", bus.commit_pc, 32'h100);
    chk("ooo_lrd0", bus.commit_lrd, 5'd0);
    chk("ooo_res0", bus.commit_result, 32'hB);
    tick();
    chk("ooo_pc1", bus.commit_pc, 32'h104);
    chk("ooo_prd1", bus.commit_prd, 6'd1);
    chk("ooo_store1", bus.commit_is_store, 1);
    chk("ooo_res1", bus.commit_result, 32'hC);
    tick();
    chk("ooo_pc2", bus.commit_pc, 32'h108);
    chk("ooo_load2", bus.commit_is_load, 1);
    chk("ooo_res2", bus.commit_result, 32'hA);
    tick(); clr(); #1;
    chk("ooo_empty", bus.empty, 1);
    chk("ooo_cv_end", bus.commit_valid, 0);
    chk("ooo_count_end", bus.count, 0);

    // mispredict: predicted not taken, resolved taken to 0x400
    do_reset();
    set_alloc(32'h200, 1'b1, 1'b0, 32'h0);
    tick();
    for (int k = 1; k < 4; k++) begin
      set_alloc(32'h300 + 32'(4*k), 1'b0, 1'b0, 32'h0);
      tick();
    end
    clr();
    set_wb(1, 4'd0, 32'h0, 1'b1, 32'h400);
    tick(); clr();
    bus.commit_ready = 1'b1;
    set_alloc(32'h900, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mp1_flush", bus.flush, 1);
    chk("mp1_redirect", bus.redirect_pc, 32'h400);
    chk("mp1_alloc_ready", bus.alloc_ready, 0);
    chk("mp1_count_before", bus.count, 4);
    tick(); clr(); #1;
    chk("mp1_count_after", bus.count, 0);
    chk("mp1_empty_after", bus.empty, 1);
    chk("mp1_tail_after", bus.alloc_idx, 1);
    chk("mp1_flush_after", bus.flush, 0);
    chk("mp1_redirect_after", bus.redirect_pc, 0);

    // predicted taken to 0x400, resolved not taken
    set_alloc(32'h200, 1'b1, 1'b1, 32'h400);
    tick(); clr();
    set_wb(0, 4'd1, 32'h0, 1'b0, 32'h0);
    tick(); clr();
    bus.commit_ready = 1'b1;
    #1;
    chk("mp2_flush", bus.flush, 1);
    chk("mp2_redirect", bus.redirect_pc, 32'h204);
    tick(); clr(); #1;
    chk("mp2_count_after", bus.count, 0);
    chk("mp2_tail_after", bus.alloc_idx, 2);

    // predicted taken to 0x400, resolved taken to 0x400: no flush
    set_alloc(32'h200, 1'b1, 1'b1, 32'h400);
    tick(); clr();
    set_wb(0, 4'd2, 32'h77, 1'b1, 32'h400);
    tick(); clr();
    bus.commit_ready = 1'b1;
    #1;
    chk("mp3_commit_valid", bus.commit_valid, 1);
    chk("mp3_flush", bus.flush, 0);
    chk("mp3_redirect", bus.redirect_pc, 0);
    chk("mp3_result", bus.commit_result, 32'h77);
    tick(); clr(); #1;
    chk("mp3_empty_after", bus.empty, 1);
    chk("mp3_tail_after", bus.alloc_idx, 3);

    // non-branch with a taken writeback never flushes
    set_alloc(32'h500, 1'b0, 1'b0, 32'h0);
    tick(); clr();
    set_wb(0, 4'd3, 32'h1, 1'b1, 32'h900);
    tick(); clr();
    bus.commit_ready = 1'b1;
    #1;
    chk("nb_commit_valid", bus.commit_valid, 1);
    chk("nb_flush", bus.flush, 0);
    tick(); clr();

    // port priority on same index, ignored writeback to unallocated index
    do_reset();
    for (int k = 0; k < 6; k++) begin
      set_alloc(32'h100 + 32'(4*k), 1'b0, 1'b0, 32'h0);
      tick();
    end
    clr();
    for (int k = 0; k < 5; k++) begin
      set_wb(0, 4'(k), 32'h50 + 32'(k), 1'b0, 32'h0);
      tick(); clr();
    end
    set_wb(0, 4'd5, 32'h11, 1'b0, 32'h0);
    set_wb(1, 4'd5, 32'h22, 1'b0, 32'h0);
    tick(); clr();
    set_wb(0, 4'd9, 32'h99, 1'b0, 32'h0);
    tick(); clr(); #1;
    chk("inv_wb_count", bus.count, 6);
    chk("inv_wb_tail", bus.alloc_idx, 6);
    bus.commit_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("prio_commit_valid", bus.commit_valid, 1);
      chk("prio_result", bus.commit_result, (k == 5) ? 32'h22 : 32'h50 + 32'(k));
      tick();
    end
    clr(); #1;
    chk("prio_empty", bus.empty, 1);
    chk("prio_cv_end", bus.commit_valid, 0);

    // streaming allocate/commit pairs across two pointer wraps
    do_reset();
    set_alloc(32'h1000, 1'b0, 1'b0, 32'h0);
    tick(); clr();
    for (int i = 0; i < 40; i++) begin
      set_wb(i % 2, 4'(i % 16), 32'(i), 1'b0, 32'h0);
      #1;
      chk("str_cv_pre", bus.commit_valid, 0);
      tick(); clr();
      bus.commit_ready = 1'b1;
      pc = 32'h1000 + 32'(4*(i+1));
      set_alloc(pc, 1'b0, 1'b0, 32'h0);
      #1;
      chk("str_cv", bus.commit_valid, 1);
      chk("str_pc", bus.commit_pc, 32'h1000 + 32'(4*i));
      chk("str_result", bus.commit_result, 32'(i));
      chk("str_alloc_idx", bus.alloc_idx, 64'((i+1) % 16));
      chk("str_count_during", bus.count, 1);
      tick(); clr(); #1;
      chk("str_count_after", bus.count, 1);
    end

    // asynchronous reset mid-stream, away from any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_empty", bus.empty, 1);
    chk("async_rst_tail", bus.alloc_idx, 0);
    chk("async_rst_cv", bus.commit_valid, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
Parametrised reorder buffer, the successor to the single-port ROB storage array.
- Owns head/tail pointers and occupancy instead of taking them from outside.
- Accepts one in-order allocation per cycle from rename, WB_PORTS out-of-order completions per cycle from execute, and one in-order retirement per cycle to the commit stage.
- Resolves branch mispredicts at retirement, driving flush and redirect_pc, which were previously tied off.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4
IDX_W, $clog2(DEPTH), entry index width
PC_W, 32, PC width
AREG_W, 5, architectural register index width
PREG_W, 6, physical register index width
DATA_W, 32, result width
WB_PORTS, 2, number of completion ports

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  rename presents an instruction
alloc_ready  out  1  high when !full && !flush
alloc_pc  in  PC_W  instruction PC
alloc_lrd  in  AREG_W  logical destination register
alloc_prd  in  PREG_W  physical destination register
alloc_is_store  in  1  store flag
alloc_is_load  in  1  load flag
alloc_is_branch  in  1  branch flag
alloc_pred_taken  in  1  predicted direction
alloc_pred_target  in  PC_W  predicted target
alloc_idx  out  IDX_W  tail index, valid in the cycle it is presented
wb_valid  in  WB_PORTS  one completion strobe per port
wb_idx  in  WB_PORTS*IDX_W  ROB index per port
wb_result  in  WB_PORTS*DATA_W  result per port
wb_taken  in  WB_PORTS  actual branch direction per port
wb_target  in  WB_PORTS*PC_W  actual branch target per port
commit_valid  out  1  head entry valid and done
commit_ready  in  1  commit stage accepts
commit_pc  out  PC_W  head entry PC
commit_lrd  out  AREG_W  head logical destination
commit_prd  out  PREG_W  head physical destination
commit_result  out  DATA_W  head result
commit_is_store  out  1  head store flag
commit_is_load  out  1  head load flag
flush  out  1  mispredicted branch retiring this cycle
redirect_pc  out  PC_W  corrected fetch PC
count  out  IDX_W+1  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Pointers: head and tail are IDX_W+1 bits each, with the MSB as the wrap bit.
  - full = index bits equal and wrap bits differ.
  - empty = pointers equal.
  - count = tail - head, modulo 2^(IDX_W+1).
- Reset (async, rst_n low): head = tail = 0 and all valid/done bits = 0. Resulting outputs:
  - alloc_ready = 1, commit_valid = 0, flush = 0, redirect_pc = 0, count = 0, empty = 1, full = 0.
  - Entry payload fields are don't-care.
  - Reset asserted mid-operation discards all entries immediately.
- Allocate: on alloc_valid && alloc_ready, the entry at tail is written with valid = 1, done = 0 and the alloc_* fields; tail increments. alloc_idx = tail[IDX_W-1:0] combinationally.
- Writeback: for each port p with wb_valid[p], if entry wb_idx[p] is valid, set done = 1 and latch result, taken and target.
  - Writeback to an invalid entry is ignored.
  - Two ports naming the same index: the highest-numbered port wins.
  - Writeback is visible to commit on the next cycle (single-cycle latency).
- Commit:
  - commit_valid = valid[head] && done[head].
  - Retire on commit_valid && commit_ready: clear valid[head], head increments.
  - commit_* outputs read the head entry combinationally.
- Mispredict: a retiring branch is mispredicted if pred_taken != taken, or if taken && pred_target != target.
  - flush is combinational, high only in the retire cycle.
  - redirect_pc = target if taken, else pc + 4, truncated to PC_W. redirect_pc = 0 when flush is low.
  - On that edge: all valid bits clear, and head and tail both take head + 1. The mispredicted branch itself retires.
  - alloc_ready is low during flush, so no allocation occurs.
- Non-branch entries never assert flush.
- Simultaneous allocate and commit: count is unchanged and both take effect.
- Full: alloc_ready = 0. There is no same-cycle allocate-on-retire when full.
- Empty: commit_valid = 0.
- Wrap-around: indices roll from DEPTH-1 to 0 and the wrap bit toggles.

Optional Feature:
ROB_WB_BYPASS_EN
- Defined: a writeback port hitting the head index in the current cycle makes commit_valid high that cycle. commit_result, and the taken/target used for mispredict resolution, come from that port; highest port wins.
- Undefined: writeback becomes visible one cycle later, as above.

Test Plan:
- Reset, then allocate 16 entries with pc = 0x100 + 4k and no writeback -> full = 1, alloc_ready = 0, count = 16, commit_valid = 0.
- Allocate 3 entries; writeback idx 2, then 0, then 1 with results 0xA, 0xB, 0xC -> retires in order idx 0, 1, 2 with commit_result 0xB, 0xC, 0xA; empty = 1 afterwards.
- Branch at idx 0, pc = 0x200, pred_taken = 0; younger entries at idx 1-3; writeback taken = 1, target = 0x400 -> flush = 1 and redirect_pc = 0x400 in the retire cycle; next cycle count = 0, head = tail = 1.
- Same branch predicted taken to 0x400, resolved not taken -> flush = 1, redirect_pc = 0x204. Predicted taken to 0x400 and resolved taken to 0x400 -> flush = 0.
- Both ports write idx 5 in the same cycle, port 0 result 0x11 and port 1 result 0x22 -> committed result is 0x22. Writeback to an unallocated idx -> no state change.
- Run 40 allocate/commit pairs with DEPTH = 16 -> pointers wrap twice; count stays at or below 1; tags commit in order; rst_n pulsed low mid-stream clears count to 0 asynchronously.
